// File: rtl/mem_stage_responder_pkg.sv
// Shared definitions for the pipeline MEM stage: stage codes, responder FSM
// states, access size codes and the store-side lane helpers.
package mem_stage_responder_pkg;

    typedef enum logic [2:0] {
        STG_IF  = 3'd0,
        STG_ID  = 3'd1,
        STG_EX  = 3'd2,
        STG_MEM = 3'd3,
        STG_WB  = 3'd4
    } stage_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_HOLD   = 3'd4
    } msr_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Wide enough for the largest supported read latency (7).
    localparam int CNT_W = 3;

    function automatic logic access_error(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = off[0];
            SZ_WORD: err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001 << off;
            SZ_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Narrow stores are copied onto every lane so the byte enables alone pick the target.
    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{wdata[7:0]}};
            SZ_HALF: rep = {2{wdata[15:0]}};
            default: rep = wdata;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/mem_stage_responder_load_extend.sv
// Load lane select and sign/zero extension; purely combinational.
module mem_stage_responder_load_extend
    import mem_stage_responder_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata[7:0];
        case (off)
            2'd0: byte_v = rdata[7:0];
            2'd1: byte_v = rdata[15:8];
            2'd2: byte_v = rdata[23:16];
            2'd3: byte_v = rdata[31:24];
            default: byte_v = rdata[7:0];
        endcase
        half_v = off[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (size)
            SZ_BYTE: data = {{24{sign & byte_v[7]}}, byte_v};
            SZ_HALF: data = {{16{sign & half_v[15]}}, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_responder.sv
// MEM-stage responder: turns one held request into one RAM access and one
// registered completion pulse.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | waiting for req_valid; errors short-circuit to ST_DONE
// ST_ACCESS | ram_en high for this single cycle (with byte enables on stores)
// ST_WAIT   | load in flight; down-counter reaches 0 on the data-valid cycle
// ST_DONE   | resp_done (and resp_err) high for this single cycle
// ST_HOLD   | waiting for req_valid to drop so a held request is served once
module mem_stage_responder
    import mem_stage_responder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    output logic              resp_done,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_lat
        $error("mem_stage_responder: RD_LAT must be within 1..7");
    end

    msr_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [1:0]        off_q, off_d;
    logic              resp_done_q, resp_done_d;
    logic              resp_err_q, resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              ram_en_q, ram_en_d;
    logic [3:0]        ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [31:0]       ext_data;

    // Address bits above the RAM word range select nothing here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    mem_stage_responder_load_extend load_extend (
        .rdata (ram_rdata),
        .off   (off_q),
        .size  (size_q),
        .sign  (sign_q),
        .data  (ext_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        sign_d       = sign_q;
        off_d        = off_q;
        resp_rdata_d = resp_rdata_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        resp_done_d  = 1'b0;
        resp_err_d   = 1'b0;
        ram_en_d     = 1'b0;
        ram_we_d     = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (access_error(req_size, req_addr[1:0])) begin
                        state_d     = ST_DONE;
                        resp_done_d = 1'b1;
                        resp_err_d  = 1'b1;
                    end else begin
                        state_d     = ST_ACCESS;
                        we_d        = req_we;
                        size_d      = req_size;
                        sign_d      = req_sign;
                        off_d       = req_addr[1:0];
                        ram_addr_d  = req_addr[ADDR_W+1:2];
                        ram_wdata_d = replicate(req_size, req_wdata);
                        ram_en_d    = 1'b1;
                        ram_we_d    = req_we ? store_mask(req_size, req_addr[1:0]) : 4'b0000;
                    end
                end
            end
            ST_ACCESS: begin
                if (we_q) begin
                    state_d     = ST_DONE;
                    resp_done_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(RD_LAT - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d      = ST_DONE;
                    resp_rdata_d = ext_data;
                    resp_done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!req_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            sign_q       <= 1'b0;
            off_q        <= 2'b00;
            resp_done_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 4'b0000;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            off_q        <= off_d;
            resp_done_q  <= resp_done_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    assign resp_done  = resp_done_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_mem_stage_responder.sv
// Bench for mem_stage_responder: synchronous RAM model with RD_LAT pipeline,
// directed cases, then random traffic checked against a shadow memory.
module tb_mem_stage_responder;

    localparam int ADDR_W = 10;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic [1:0]        req_size = 2'b00;
    logic              req_sign = 1'b0;
    logic              resp_done;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    always #5 clk = ~clk;

    mem_stage_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_sign   (req_sign),
        .resp_done  (resp_done),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // RAM model: data captured at the edge that sees ram_en, visible RD_LAT cycles later.
    logic [31:0] mem     [0:DEPTH-1];
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] rd_pipe [0:RD_LAT-1];
    logic        fill_en = 1'b0;

    function automatic logic [31:0] init_val(input int idx);
        return (idx * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (ram_en) begin
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
        rd_pipe[0] <= ram_en ? mem[ram_addr] : 32'hBAD0_BAD0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input int off,
                                             input int sz, input bit sgn);
        int bits;
        longint unsigned v, m;
        bits = 8 << sz;
        m    = (64'd1 << bits) - 1;
        v    = (longint'(word) >> (8 * off)) & m;
        if (sgn && (((v >> (bits - 1)) & 1) == 1)) v = v | ~m;
        return v[31:0];
    endfunction

    logic [31:0] last_rdata = '0;
    logic [3:0]  cap_we;
    logic [31:0] cap_addr, cap_wdata, cap_rdata;
    logic        cap_err;
    int          cap_done_at;

    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic sign,
                           input bit drop_early, input int hold);
        bit          exp_err;
        int          off, nbytes, exp_lat, wa, k, stop_k, en_cnt, done_cnt, stray;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata, exp_rdata;

        off     = int'(addr[1:0]);
        exp_err = (size == 2'd3) || (size == 2'd1 && (off % 2) != 0) || (size == 2'd2 && off != 0);
        nbytes  = 1 << size;
        exp_lat = exp_err ? 1 : (we ? 2 : 2 + RD_LAT);
        wa      = int'((addr >> 2) % DEPTH);
        exp_mask  = we ? 4'(((1 << nbytes) - 1) << off) : 4'b0000;
        exp_wdata = (size == 2'd0) ? wdata[7:0] * 32'h0101_0101 :
                    (size == 2'd1) ? wdata[15:0] * 32'h0001_0001 : wdata;
        exp_rdata = exp_err ? 32'h0 : ref_load(ref_mem[wa], off, int'(size), sign);

        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_sign = sign;
        req_valid = 1'b1;
        k = 0; stop_k = 30 + hold; en_cnt = 0; done_cnt = 0; stray = 0;
        cap_done_at = -1; cap_err = 1'b0;
        cap_we = '0; cap_addr = '0; cap_wdata = '0; cap_rdata = '0;
        while (k < stop_k) begin
            @(posedge clk); #1;
            k++;
            if (k == 1) begin
                req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
                req_size = 2'($urandom); req_sign = 1'($urandom);
                if (drop_early) req_valid = 1'b0;
            end
            if (ram_en) begin
                en_cnt++;
                cap_we = ram_we; cap_addr = 32'(ram_addr); cap_wdata = ram_wdata;
            end else if (ram_we != 4'b0000) stray++;
            if (resp_done) begin
                done_cnt++;
                if (cap_done_at < 0) begin
                    cap_done_at = k; cap_err = resp_err; cap_rdata = resp_rdata;
                    stop_k = k + hold + 2;
                end
            end else if (resp_err) stray++;
            if (cap_done_at >= 0 && k >= cap_done_at + hold) req_valid = 1'b0;
        end
        req_valid = 1'b0;

        chk("latency", cap_done_at, exp_lat);
        chk("done_count", done_cnt, 1);
        chk("err", cap_err, exp_err);
        chk("ram_en_count", en_cnt, exp_err ? 0 : 1);
        chk("stray_we_or_err", stray, 0);
        if (!exp_err) begin
            chk("ram_addr", cap_addr, wa);
            chk("ram_we", cap_we, exp_mask);
            if (we) begin
                chk("ram_wdata", cap_wdata, exp_wdata);
                for (int i = 0; i < 4; i++)
                    if (exp_mask[i]) ref_mem[wa][8*i +: 8] = exp_wdata[8*i +: 8];
            end else begin
                chk("rdata", cap_rdata, exp_rdata);
                last_rdata = exp_rdata;
            end
        end
        if (we || exp_err) chk("rdata_held", resp_rdata, last_rdata);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        fill_en = 1'b1;
        #1;
        chk("rst_ctrl", {25'd0, resp_done, resp_err, ram_en, ram_we}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        chk("rst_addr", 32'(ram_addr), 32'h0);
        @(posedge clk); #1;
        fill_en = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 0);
        chk("d_word_we", cap_we, 32'hF);
        chk("d_word_addr", cap_addr, 32'd4);
        chk("d_word_lat", cap_done_at, 32'd2);

        run_txn(1'b1, 32'h10, 32'h80FF_0000, 2'b10, 1'b0, 1'b0, 0);
        run_txn(1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 1'b0, 0);
        chk("d_sbyte", cap_rdata, 32'hFFFF_FF80);
        chk("d_sbyte_lat", cap_done_at, 32'd4);
        run_txn(1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 1'b0, 0);
        chk("d_ubyte", cap_rdata, 32'h0000_0080);

        run_txn(1'b1, 32'h22, 32'h0000_1234, 2'b01, 1'b0, 1'b0, 0);
        chk("d_half_we", cap_we, 32'hC);
        chk("d_half_wdata", cap_wdata, 32'h1234_1234);

        run_txn(1'b0, 32'h02, 32'h0, 2'b10, 1'b0, 1'b0, 0);
        chk("d_mis_err", cap_err, 32'h1);
        chk("d_mis_lat", cap_done_at, 32'd1);

        run_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 10);
        run_txn(1'b1, 32'h44, 32'h0000_00A5, 2'b00, 1'b0, 1'b0, 10);
        run_txn(1'b0, 32'h46, 32'h0, 2'b01, 1'b1, 1'b1, 0);

        // Reset while the load is in WAIT.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_size = 2'b10; req_sign = 1'b0; req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("mid_rst_ctrl", {25'd0, resp_done, resp_err, ram_en, ram_we}, 32'h0);
        chk("mid_rst_rdata", resp_rdata, 32'h0);
        chk("mid_rst_wdata", ram_wdata, 32'h0);
        chk("mid_rst_addr", 32'(ram_addr), 32'h0);
        last_rdata = '0;
        begin
            int seen;
            seen = 0;
            repeat (3) begin @(posedge clk); #1; if (resp_done || ram_en) seen++; end
            @(negedge clk); reset_n = 1'b1;
            repeat (4) begin @(posedge clk); #1; if (resp_done || ram_en) seen++; end
            chk("mid_rst_quiet", seen, 0);
        end
        run_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, 0);

        for (int t = 0; t < 80; t++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            a  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_txn(1'($urandom), a, $urandom, sz, 1'($urandom),
                    ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_responder.md
MEM_STAGE_RESPONDER -- requirements
Module: mem_stage_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of data RAM.
REQ-002 SHALL have parameter RD_LAT, default 2, RAM read latency in cycles, legal range 1..7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  MEM-stage access request from stage sequencer; level, held until resp_done.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data, right-aligned.
REQ-009 req_size  input  2  00 byte, 01 half, 10 word; 11 reserved, treated as error.
REQ-010 req_sign  input  1  1 = sign-extend loads, 0 = zero-extend.
REQ-011 resp_done  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data, held until next load completes.
REQ-013 resp_err  output  1  misalignment/size error, valid with resp_done.
REQ-014 ram_en  output  1  RAM enable.
REQ-015 ram_we  output  4  byte write enables, bit i = byte lane i (little-endian).
REQ-016 ram_addr  output  ADDR_W  word address = req_addr[ADDR_W+1:2].
REQ-017 ram_wdata  output  32  lane-replicated store data.
REQ-018 ram_rdata  input  32  RAM read data, valid RD_LAT cycles after ram_en edge.

Function
REQ-019 SHALL implement FSM IDLE, ACCESS, WAIT, DONE, HOLD; all outputs registered.
REQ-020 IDLE, req_valid=1: error (half with addr[0]=1, word with addr[1:0]!=0, size 11) -> DONE with resp_err=1, no RAM activity; else latch request -> ACCESS.
REQ-021 ACCESS: ram_en=1 one cycle; store -> ram_we mask per size/addr[1:0], then DONE; load -> ram_we=0000, then WAIT.
REQ-022 WAIT: count RD_LAT-1 cycles, then sample ram_rdata, select lane by addr[1:0], extend per size/sign into resp_rdata, -> DONE.
REQ-023 Store data SHALL be replicated: byte -> 4 copies, half -> 2 copies.
REQ-024 DONE: resp_done=1 one cycle -> HOLD; HOLD -> IDLE when req_valid=0 (one access per request).
REQ-025 Latency from IDLE-sampling cycle N: error done at N+1; store done at N+2; load done at N+2+RD_LAT.
REQ-026 req_valid deasserted mid-access SHALL NOT abort; access completes, resp_done pulses, HOLD exits next cycle.
REQ-027 Request inputs SHALL be ignored outside IDLE; latched copy used throughout.
REQ-028 resp_err SHALL be 0 whenever resp_done=0; ram_en/ram_we 0 outside ACCESS.

Reset
REQ-029 reset_n low SHALL immediately force IDLE, counter 0, resp_done/resp_err/ram_en 0, ram_we 0000, resp_rdata/ram_wdata/ram_addr 0.
REQ-030 Reset mid-operation SHALL abandon access with no resp_done; first request after release accepted normally.

Structure
REQ-031 FSM state encodings and req_size codes SHALL live in the shared define package next to the stage codes.
REQ-032 Lane-select/extension logic SHALL be one combinational sub-module, load_extend.

Verification
REQ-033 Word store addr 0x10 data 0xDEADBEEF -> ram_we=1111, ram_addr=4 at N+1, resp_done at N+2, err=0.
REQ-034 Signed byte load addr 0x13, RAM word 0x80FF0000, RD_LAT=2 -> resp_rdata=0xFFFFFF80 at N+4; unsigned -> 0x00000080.
REQ-035 Half store addr 0x22 data 0x1234 -> ram_we=1100, ram_wdata=0x12341234.
REQ-036 Word load addr 0x02 -> resp_err=1, resp_done at N+1, ram_en never asserted.
REQ-037 req_valid held 10 cycles after done -> exactly one ram_en pulse and one resp_done.
REQ-038 reset_n pulsed low in WAIT -> outputs zero immediately, no resp_done; next load completes normally.
